// File: rtl/xgmac_stats_pkg.sv
// Shared constants for the 10G MAC statistics / pause glue: vector field
// positions, counter indices, host word map and the pause state encoding.
package xgmac_stats_pkg;

  localparam int unsigned RX_VEC_W = 30;
  localparam int unsigned TX_VEC_W = 26;
  localparam int unsigned BYTE_W   = 14;
  localparam int unsigned PAUSE_W  = 16;

  localparam int unsigned RX_GOOD_BIT  = 0;
  localparam int unsigned RX_BAD_BIT   = 1;
  localparam int unsigned RX_BYTES_LSB = 2;
  localparam int unsigned TX_GOOD_BIT  = 0;
  localparam int unsigned TX_BYTES_LSB = 1;

  localparam int unsigned NUM_CNT        = 6;
  localparam int unsigned CNT_RX_GOOD    = 0;
  localparam int unsigned CNT_RX_BAD     = 1;
  localparam int unsigned CNT_RX_BYTES   = 2;
  localparam int unsigned CNT_TX_GOOD    = 3;
  localparam int unsigned CNT_TX_BYTES   = 4;
  localparam int unsigned CNT_PAUSE_SENT = 5;

  // Word 2k = counter k low half, word 2k+1 = shared shadow; words >= WORD_RSVD read 0
  localparam int unsigned RD_W      = 32;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned WORD_RSVD = 2 * NUM_CNT;

  typedef enum logic {
    IDLE = 1'b0,
    XOFF = 1'b1
  } pause_state_e;

endpackage

// File: rtl/xgmac_sat_cnt.sv
// Saturating accumulator: adds inc every cycle, sticks at all-ones, clr wins.
module xgmac_sat_cnt
  import xgmac_stats_pkg::*;
#(
  parameter int unsigned CNT_W = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic [BYTE_W-1:0]   inc,
  output logic [CNT_W-1:0]    cnt
);

  logic [CNT_W:0] sum_c;

  assign sum_c = {1'b0, cnt} + (CNT_W+1)'(inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (sum_c[CNT_W]) begin
      cnt <= '1;
    end else begin
      cnt <= sum_c[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/xgmac_stats_pause.sv
// MAC statistics accumulation with torn-read-safe host access, plus
// 802.3x XOFF/XON generation from RX buffer fill with hysteresis and refresh.
module xgmac_stats_pause
  import xgmac_stats_pkg::*;
#(
  parameter int unsigned   CNT_W        = 48,
  parameter int unsigned   LVL_W        = 12,
  parameter int unsigned   HI_WM        = 3072,
  parameter int unsigned   LO_WM        = 1024,
  parameter logic [15:0]   PAUSE_QUANTA = 16'hFFFF,
  parameter int unsigned   REFRESH_CYC  = 4096
) (
  input  logic                 clk156,
  input  logic                 aresetn,
  input  logic                 rx_statistics_valid,
  input  logic [RX_VEC_W-1:0]  rx_statistics_vector,
  input  logic                 tx_statistics_valid,
  input  logic [TX_VEC_W-1:0]  tx_statistics_vector,
  input  logic [LVL_W-1:0]     fifo_level,
  input  logic                 pause_enable,
  output logic                 pause_req,
  output logic [PAUSE_W-1:0]   pause_val,
  input  logic [ADDR_W-1:0]    stat_addr,
  input  logic                 stat_rd,
  output logic [RD_W-1:0]      stat_rdata,
  output logic                 stat_rdack,
  input  logic                 stat_clr
);

  localparam int unsigned SHD_W = CNT_W - RD_W;
  localparam int unsigned REF_W = (REFRESH_CYC > 2) ? $clog2(REFRESH_CYC) : 1;

  logic [BYTE_W-1:0] inc [NUM_CNT];
  logic [CNT_W-1:0]  cnt [NUM_CNT];
  logic              pulse_c;

  // Fields outside the counted ones are intentionally ignored
  logic unused_vec_bits;
  assign unused_vec_bits = ^{rx_statistics_vector[RX_VEC_W-1:RX_BYTES_LSB+BYTE_W],
                             tx_statistics_vector[TX_VEC_W-1:TX_BYTES_LSB+BYTE_W]};

  always_comb begin
    inc[CNT_RX_GOOD]    = BYTE_W'(rx_statistics_valid & rx_statistics_vector[RX_GOOD_BIT]);
    inc[CNT_RX_BAD]     = BYTE_W'(rx_statistics_valid & rx_statistics_vector[RX_BAD_BIT]);
    inc[CNT_RX_BYTES]   = rx_statistics_valid ? rx_statistics_vector[RX_BYTES_LSB +: BYTE_W] : '0;
    inc[CNT_TX_GOOD]    = BYTE_W'(tx_statistics_valid & tx_statistics_vector[TX_GOOD_BIT]);
    inc[CNT_TX_BYTES]   = tx_statistics_valid ? tx_statistics_vector[TX_BYTES_LSB +: BYTE_W] : '0;
    inc[CNT_PAUSE_SENT] = BYTE_W'(pulse_c);
  end

  xgmac_sat_cnt #(.CNT_W(CNT_W)) u_rx_good (
    .clk(clk156), .rst_n(aresetn), .clr(stat_clr), .inc(inc[CNT_RX_GOOD]), .cnt(cnt[CNT_RX_GOOD]));
  xgmac_sat_cnt #(.CNT_W(CNT_W)) u_rx_bad (
    .clk(clk156), .rst_n(aresetn), .clr(stat_clr), .inc(inc[CNT_RX_BAD]), .cnt(cnt[CNT_RX_BAD]));
  xgmac_sat_cnt #(.CNT_W(CNT_W)) u_rx_bytes (
    .clk(clk156), .rst_n(aresetn), .clr(stat_clr), .inc(inc[CNT_RX_BYTES]), .cnt(cnt[CNT_RX_BYTES]));
  xgmac_sat_cnt #(.CNT_W(CNT_W)) u_tx_good (
    .clk(clk156), .rst_n(aresetn), .clr(stat_clr), .inc(inc[CNT_TX_GOOD]), .cnt(cnt[CNT_TX_GOOD]));
  xgmac_sat_cnt #(.CNT_W(CNT_W)) u_tx_bytes (
    .clk(clk156), .rst_n(aresetn), .clr(stat_clr), .inc(inc[CNT_TX_BYTES]), .cnt(cnt[CNT_TX_BYTES]));
  xgmac_sat_cnt #(.CNT_W(CNT_W)) u_pause_sent (
    .clk(clk156), .rst_n(aresetn), .clr(stat_clr), .inc(inc[CNT_PAUSE_SENT]), .cnt(cnt[CNT_PAUSE_SENT]));

  // Host read path: low word direct, high word from the single shared shadow
  logic [2:0]       rd_idx;
  logic [RD_W-1:0]  rd_word_c;
  logic [SHD_W-1:0] rd_hi_c;
  logic [SHD_W-1:0] shadow;
  logic             rd_in_map;

  assign rd_idx    = stat_addr[ADDR_W-1:1];
  assign rd_in_map = stat_addr < ADDR_W'(WORD_RSVD);

  always_comb begin
    rd_word_c = '0;
    rd_hi_c   = '0;
    if (rd_in_map) begin
      rd_hi_c = cnt[rd_idx][CNT_W-1:RD_W];
      if (stat_addr[0]) begin
        rd_word_c = RD_W'(shadow);
      end else begin
        rd_word_c = cnt[rd_idx][RD_W-1:0];
      end
    end
  end

  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      stat_rdata <= '0;
      stat_rdack <= 1'b0;
      shadow     <= '0;
    end else begin
      stat_rdack <= stat_rd;
      if (stat_rd) begin
        stat_rdata <= rd_word_c;
      end
      if (stat_clr) begin
        shadow <= '0;
      end else if (stat_rd && rd_in_map && !stat_addr[0]) begin
        shadow <= rd_hi_c;
      end
    end
  end

  // Pause FSM: hysteresis between watermarks, periodic XOFF refresh
  pause_state_e     state, state_nxt;
  logic [REF_W-1:0] refresh_cnt, refresh_nxt;
  logic [PAUSE_W-1:0] val_c;
  logic             exit_c;

  assign exit_c = !pause_enable || (fifo_level < LVL_W'(LO_WM));

  always_comb begin
    state_nxt   = state;
    refresh_nxt = refresh_cnt;
    pulse_c     = 1'b0;
    val_c       = pause_val;
    case (state)
      IDLE: begin
        if (pause_enable && (fifo_level >= LVL_W'(HI_WM))) begin
          state_nxt   = XOFF;
          refresh_nxt = REF_W'(REFRESH_CYC - 1);
          pulse_c     = 1'b1;
          val_c       = PAUSE_QUANTA;
        end
      end
      XOFF: begin
        if (exit_c) begin
          state_nxt   = IDLE;
          refresh_nxt = '0;
          pulse_c     = 1'b1;
          val_c       = '0;
        end else if (refresh_cnt == '0) begin
          refresh_nxt = REF_W'(REFRESH_CYC - 1);
          pulse_c     = 1'b1;
          val_c       = PAUSE_QUANTA;
        end else begin
          refresh_nxt = refresh_cnt - REF_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      refresh_cnt <= '0;
      pause_req   <= 1'b0;
      pause_val   <= '0;
    end else begin
      state       <= state_nxt;
      refresh_cnt <= refresh_nxt;
      pause_req   <= pulse_c;
      pause_val   <= val_c;
    end
  end

endmodule
